// File: rtl/sholva_pkg.sv
// Shared constants for the operand fetch stage and its neighbours.
package sholva_pkg;

    localparam int NREGS = 8;
    localparam int REG_W = 32;

    localparam logic [REG_W-1:0] EFLAGS_RESET = 32'h0000_0002;

    localparam logic [2:0] REG_EAX = 3'd0;
    localparam logic [2:0] REG_ECX = 3'd1;
    localparam logic [2:0] REG_EDX = 3'd2;
    localparam logic [2:0] REG_EBX = 3'd3;
    localparam logic [2:0] REG_ESP = 3'd4;
    localparam logic [2:0] REG_EBP = 3'd5;
    localparam logic [2:0] REG_ESI = 3'd6;
    localparam logic [2:0] REG_EDI = 3'd7;

endpackage

// File: rtl/regfile.sv
// General-purpose register file: two combinational read ports, one write port.
module regfile #(
    parameter int NREGS = sholva_pkg::NREGS,
    parameter int REG_W = sholva_pkg::REG_W,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd0_idx,
    output logic [REG_W-1:0] rd0_data,
    input  logic [IDX_W-1:0] rd1_idx,
    output logic [REG_W-1:0] rd1_data,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [REG_W-1:0] wr_data
);

    logic [REG_W-1:0] gpr_r [NREGS];

    // Register storage: cleared on reset, single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                gpr_r[i] <= '0;
            end
        end else if (we) begin
            gpr_r[wr_idx] <= wr_data;
        end
    end

    assign rd0_data = gpr_r[rd0_idx];
    assign rd1_data = gpr_r[rd1_idx];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: scoreboarded issue of decoded micro-ops with writeback
// forwarding and a registered operand bundle toward execute.
module operand_fetch
    import sholva_pkg::EFLAGS_RESET;
#(
    parameter int NREGS = sholva_pkg::NREGS,
    parameter int REG_W = sholva_pkg::REG_W,
    parameter int OPC_W = 6,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [OPC_W-1:0] dec_opc,
    input  logic [IDX_W-1:0] dec_src0_sel,
    input  logic [IDX_W-1:0] dec_src1_sel,
    input  logic             dec_src0_imm,
    input  logic             dec_src1_imm,
    input  logic [REG_W-1:0] dec_imm0,
    input  logic [REG_W-1:0] dec_imm1,
    input  logic [IDX_W-1:0] dec_dst,
    input  logic             dec_dst_we,
    input  logic             dec_flags_re,
    input  logic             dec_flags_we,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [OPC_W-1:0] ex_opc,
    output logic [REG_W-1:0] ex_eflags,
    output logic [REG_W-1:0] ex_opnd0_r,
    output logic [REG_W-1:0] ex_opnd1_r,
    output logic [IDX_W-1:0] ex_dst,
    output logic             ex_dst_we,
    output logic             ex_flags_we,
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_dst,
    input  logic             wb_we,
    input  logic [REG_W-1:0] wb_data,
    input  logic             wb_flags_we,
    input  logic [REG_W-1:0] wb_eflags
);

    logic [NREGS-1:0] pend_r;
    logic             pend_f_r;
    logic [REG_W-1:0] eflags_r;

    logic [NREGS-1:0] wclr_s;
    logic [NREGS-1:0] p_s;
    logic [NREGS-1:0] pend_set_s;
    logic             fclr_s;
    logic             pf_s;
    logic             hazard_s;
    logic             issue_s;
    logic [REG_W-1:0] rd0_s;
    logic [REG_W-1:0] rd1_s;
    logic [REG_W-1:0] opnd0_s;
    logic [REG_W-1:0] opnd1_s;
    logic [REG_W-1:0] eflags_s;

    regfile #(
        .NREGS (NREGS),
        .REG_W (REG_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd0_idx  (dec_src0_sel),
        .rd0_data (rd0_s),
        .rd1_idx  (dec_src1_sel),
        .rd1_data (rd1_s),
        .we       (wb_valid & wb_we),
        .wr_idx   (wb_dst),
        .wr_data  (wb_data)
    );

    // Writeback clear masks and effective pending state.
    always_comb begin
        wclr_s = '0;
        for (int i = 0; i < NREGS; i++) begin
            wclr_s[i] = wb_valid & wb_we & (wb_dst == IDX_W'(i));
        end
        fclr_s = wb_valid & wb_flags_we;
        p_s    = pend_r & ~wclr_s;
        pf_s   = pend_f_r & ~fclr_s;
    end

    // Hazard detection and handshake toward decode.
    always_comb begin
        hazard_s = (!dec_src0_imm & p_s[dec_src0_sel])
                 | (!dec_src1_imm & p_s[dec_src1_sel])
                 | (dec_dst_we    & p_s[dec_dst])
                 | (dec_flags_re  & pf_s)
                 | (dec_flags_we  & pf_s);
        dec_ready = !hazard_s & (!ex_valid | ex_ready);
        issue_s   = dec_valid & dec_ready;
    end

    // Operand resolution; a same-cycle writeback overrides the stored value.
    always_comb begin
        if (dec_src0_imm) begin
            opnd0_s = dec_imm0;
        end else if (wclr_s[dec_src0_sel]) begin
            opnd0_s = wb_data;
        end else begin
            opnd0_s = rd0_s;
        end
        if (dec_src1_imm) begin
            opnd1_s = dec_imm1;
        end else if (wclr_s[dec_src1_sel]) begin
            opnd1_s = wb_data;
        end else begin
            opnd1_s = rd1_s;
        end
        if (fclr_s) begin
            eflags_s = wb_eflags;
        end else begin
            eflags_s = eflags_r;
        end
    end

    // Pending bits set by this cycle's issue.
    always_comb begin
        pend_set_s = '0;
        if (issue_s && dec_dst_we) begin
            pend_set_s[dec_dst] = 1'b1;
        end else begin
            pend_set_s = '0;
        end
    end

    // Scoreboard and EFLAGS state; an issue setting a bit beats a clearing writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r   <= '0;
            pend_f_r <= 1'b0;
            eflags_r <= EFLAGS_RESET;
        end else begin
            pend_r   <= (pend_r & ~wclr_s) | pend_set_s;
            pend_f_r <= (pend_f_r & ~fclr_s) | (issue_s & dec_flags_we);
            if (fclr_s) begin
                eflags_r <= wb_eflags;
            end
        end
    end

    // Output bundle register; payload holds while execute back-pressures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_opc      <= '0;
            ex_eflags   <= '0;
            ex_opnd0_r  <= '0;
            ex_opnd1_r  <= '0;
            ex_dst      <= '0;
            ex_dst_we   <= 1'b0;
            ex_flags_we <= 1'b0;
        end else if (issue_s) begin
            ex_valid    <= 1'b1;
            ex_opc      <= dec_opc;
            ex_eflags   <= eflags_s;
            ex_opnd0_r  <= opnd0_s;
            ex_opnd1_r  <= opnd1_s;
            ex_dst      <= dec_dst;
            ex_dst_we   <= dec_dst_we;
            ex_flags_we <= dec_flags_we;
        end else if (ex_ready) begin
            ex_valid    <= 1'b0;
        end
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Pipeline stage directly upstream of `execute`. It accepts decoded micro-ops from decode over a valid/ready handshake and holds the architectural state: eight 32-bit GPRs and EFLAGS. It resolves each source operand to a register value or an immediate and registers `{opc, eflags, opnd0_r, opnd1_r}` toward execute. A per-register scoreboard stalls issue until results from execute have been written back, and same-cycle writeback values are forwarded to the operands.

## Interface
Parameters:
- `NREGS`, 8, number of GPRs; index width is `$clog2(NREGS)` (3)
- `REG_W`, 32, GPR, operand and EFLAGS width
- `OPC_W`, 6, opcode width, matching execute's `opc`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `dec_valid`  in  1  micro-op offered by decode
- `dec_ready`  out  1  micro-op accepted this cycle
- `dec_opc`  in  OPC_W  command code (`CMD_*`)
- `dec_src0_sel`, `dec_src1_sel`  in  3  source register indices
- `dec_src0_imm`, `dec_src1_imm`  in  1  select the immediate instead of the register
- `dec_imm0`, `dec_imm1`  in  REG_W  immediate values
- `dec_dst`  in  3  destination register
- `dec_dst_we`  in  1  micro-op writes `dec_dst`
- `dec_flags_re`  in  1  micro-op reads EFLAGS
- `dec_flags_we`  in  1  micro-op writes EFLAGS
- `ex_valid`  out  1  operand bundle valid toward execute
- `ex_ready`  in  1  execute accepts the bundle
- `ex_opc`  out  OPC_W  to execute `opc`
- `ex_eflags`  out  REG_W  to execute `eflags`
- `ex_opnd0_r`, `ex_opnd1_r`  out  REG_W  to execute operands
- `ex_dst`  out  3  destination, carried along for writeback
- `ex_dst_we`, `ex_flags_we`  out  1  write enables, carried along for writeback
- `wb_valid`  in  1  writeback strobe; always accepted
- `wb_dst`  in  3  register to write
- `wb_we`  in  1  GPR write enable (qualified by `wb_valid`)
- `wb_data`  in  REG_W  GPR result
- `wb_flags_we`  in  1  EFLAGS write enable (qualified by `wb_valid`)
- `wb_eflags`  in  REG_W  new EFLAGS value

## Operation
- State:
  - GPR[0..7]
  - EFLAGS
  - `pend[7:0]`, one pending-write bit per GPR
  - `pend_f`, pending-write bit for EFLAGS
  - one output register holding the `ex_*` bundle
- Writeback clear mask:
  - `wclr[i] = wb_valid & wb_we & (wb_dst == i)`
  - `fclr = wb_valid & wb_flags_we`
- Effective pending: `p[i] = pend[i] & ~wclr[i]`; `pf = pend_f & ~fclr`.
- Hazard is the OR of:
  - `!dec_src0_imm & p[src0]`
  - `!dec_src1_imm & p[src1]`
  - `dec_dst_we & p[dst]` (WAW)
  - `dec_flags_re & pf`
  - `dec_flags_we & pf`
- `dec_ready = !hazard & (!ex_valid | ex_ready)`. `dec_ready` may depend on the `dec_*` payload.
- Issue is `dec_valid & dec_ready`. On issue:
  - Load the output register.
  - `opndN = immN` if `dec_srcN_imm`; otherwise GPR[srcN], bypassed to `wb_data` when `wclr[srcN]`.
  - `ex_eflags` = EFLAGS, bypassed to `wb_eflags` when `fclr`.
  - Set `pend[dst]` if `dec_dst_we`; set `pend_f` if `dec_flags_we`.
- Writeback:
  - Writes GPR/EFLAGS and clears the matching pending bits.
  - If an issue in the same cycle sets the same bit, the set wins.
  - A writeback to a non-pending register still writes; the pending bit stays clear.
- `ex_valid` rules:
  - Cleared when `ex_ready & !issue`.
  - Held with a stable payload while `ex_valid & !ex_ready`.
- Both sources may name the same register, and a source may equal dst. Both cases are legal; sources read the pre-issue value.

## Timing
- Reset values (async, `rst_n` low):
  - GPRs = 0
  - EFLAGS = 32'h0000_0002
  - `pend`/`pend_f` = 0
  - `ex_valid` = 0
  - all `ex_*` payload = 0
- `dec_ready` is combinational and is 1 out of reset.
- Latency: a micro-op issued in cycle N is presented with `ex_valid=1` in cycle N+1.
- Throughput is 1 per cycle when there is no hazard and execute is always ready.
- A dependent micro-op issues in the cycle its producer's writeback arrives (forwarded), not one cycle later.
- Reset asserted mid-stall or mid-transfer discards the in-flight bundle and all pending bits immediately.

## Structure
- Shared package `sholva_pkg` holds:
  - `NREGS`, `REG_W`
  - `EFLAGS_RESET = 32'h2`
  - GPR index constants `REG_EAX..REG_EDI` (0..7)
- Sub-module `regfile`: NREGS×REG_W, two combinational read ports, one write port, async reset to 0.
- Scoreboard, forwarding and the output register live in `operand_fetch` itself.

## Test plan
- Reset, then issue `ADD`, src0=EAX (imm=0), src1=imm 5, dst=EAX → `dec_ready=1` at reset; next cycle `ex_valid=1`, `ex_opnd0_r=0`, `ex_opnd1_r=5`, `ex_eflags=2`, `pend[0]=1`.
- Back-to-back `ADD` reading EAX while `pend[0]=1`, no writeback → `dec_ready=0` and stalled. Apply `wb_valid`, `wb_dst=0`, `wb_data=7` → same-cycle issue with `ex_opnd0_r=7`.
- Hold `ex_ready=0` for 3 cycles with a second independent micro-op offered → `ex_*` payload is stable and `dec_ready=0`. Raise `ex_ready` → second bundle appears on the next cycle.
- `ADC` with `dec_flags_re=1` after a flags writer → stall until `wb_flags_we` with `wb_eflags=32'h3`, then `ex_eflags=32'h3`.
- Writeback to EBX and issue with `dst=EBX` in the same cycle → `pend[3]=1` afterwards and GPR[3] is updated.
- Assert `rst_n=0` while `ex_valid=1` and pending bits are set → `ex_valid=0`, all pending bits cleared, EFLAGS=2 without waiting for a clock edge.
